// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// The operation result is computed combinationally from the latched operands
// and committed to HI/LO only on the final busy cycle. The counter holds the
// FSM in RUN so that busy lasts exactly MUL_CYCLES or DIV_CYCLES cycles.
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic               accept;
    logic               is_div_req;
    logic               move_hi;
    logic               move_lo;
    logic               finish;

    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;
    logic               div_by_zero;
    logic               div_ovf;
    logic [WIDTH-1:0]   safe_b;
    logic signed [WIDTH-1:0] sdiv_q;
    logic signed [WIDTH-1:0] sdiv_r;
    logic [WIDTH-1:0]   udiv_q;
    logic [WIDTH-1:0]   udiv_r;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Request decode: only IDLE listens to start, so anything issued while busy is dropped.
    always_comb begin
        accept     = 1'b0;
        move_hi    = 1'b0;
        move_lo    = 1'b0;
        is_div_req = (op == OP_DIV) || (op == OP_DIVU);
        if (state_q == IDLE && start) begin
            move_hi = (op == OP_MTHI);
            move_lo = (op == OP_MTLO);
            accept  = !move_hi && !move_lo;
        end
        finish = (state_q == RUN) && (count_q == CNT_W'(1));
    end

    // Next-state logic: enter RUN on an accepted request, leave on the last counted cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (finish) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Operand preparation: sign- or zero-extend to 2*WIDTH so one multiplier serves both flavours.
    // A zero divisor or the signed min/-1 case divides by one instead; for min/-1 that
    // directly yields quotient=A and remainder=0, and a zero divisor never commits.
    always_comb begin
        is_signed   = (op_q == OP_MULT) || (op_q == OP_DIV) || (op_q == OP_MADD);
        a_ext       = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext       = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product     = a_ext * b_ext;
        div_by_zero = (b_q == '0);
        div_ovf     = (op_q == OP_DIV) && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
        safe_b      = (div_by_zero || div_ovf) ? WIDTH'(1) : b_q;
        sdiv_q      = $signed(a_q) / $signed(safe_b);
        sdiv_r      = $signed(a_q) % $signed(safe_b);
        udiv_q      = a_q / safe_b;
        udiv_r      = a_q % safe_b;
    end

    // Result selection; defaults keep HI/LO so that unwritten cases leave them untouched.
    always_comb begin
        res_hi = HI;
        res_lo = LO;
        case (op_q)
            OP_MULT, OP_MULTU: {res_hi, res_lo} = product;
            OP_MADD, OP_MADDU: {res_hi, res_lo} = {HI, LO} + product;
            OP_DIV: begin
                if (!div_by_zero) begin
                    res_lo = sdiv_q;
                    res_hi = sdiv_r;
                end
            end
            OP_DIVU: begin
                if (!div_by_zero) begin
                    res_lo = udiv_q;
                    res_hi = udiv_r;
                end
            end
            default: begin
                res_hi = HI;
                res_lo = LO;
            end
        endcase
    end

    // Datapath registers: operand latch, busy counter, HI/LO updates and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            HI      <= '0;
            LO      <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                op_q    <= op;
                a_q     <= A;
                b_q     <= B;
                count_q <= is_div_req ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end else if (state_q == RUN) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (move_hi) HI <= A;
            if (move_lo) LO <= A;
            if (finish) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a table of directed operations with
// hand-computed HI/LO results and busy lengths, plus hand-written sequences
// for back-to-back issue and reset during a running operation.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;

    localparam int NUM_VECS = 22;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int   compared   = 0;
    int   mismatched = 0;
    vec_t vecs[NUM_VECS];

    muldiv_unit #(
        .WIDTH      (32),
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive a request at the current negedge; returns at the next negedge with start released.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Starting at the negedge after the issuing edge: count busy cycles (bounded),
    // check HI/LO hold during busy, then check done and the final HI/LO.
    task automatic checkResult(input string name, input int cycles, input logic [31:0] pre_hi,
                               input logic [31:0] pre_lo, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo);
        int          busy_count;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        busy_count = 0;
        hold_hi    = HI;
        hold_lo    = LO;
        while (busy === 1'b1 && busy_count < 100) begin
            busy_count++;
            hold_hi = HI;
            hold_lo = LO;
            if (done !== 1'b0) hold_hi = ~HI;
            @(negedge clk);
        end
        if (cycles != 0) begin
            checkOutput({name, "_hold_hi"}, hold_hi, pre_hi);
            checkOutput({name, "_hold_lo"}, hold_lo, pre_lo);
        end
        checkOutput({name, "_busy_cycles"}, 32'(busy_count), 32'(cycles));
        checkOutput({name, "_done"}, {31'd0, done}, {31'd0, (cycles != 0)});
        checkOutput({name, "_hi"}, HI, exp_hi);
        checkOutput({name, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[3]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5]  = '{OP_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 10};
        vecs[6]  = '{OP_DIV,   32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2, 10};
        vecs[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[8]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[9]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, 10};
        vecs[10] = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000001, 32'h00000003, 10};
        vecs[11] = '{OP_MTHI,  32'h00000000, 32'h00000000, 32'h00000000, 32'h00000003, 0};
        vecs[12] = '{OP_MTLO,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0};
        vecs[13] = '{OP_MADDU, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000, 5};
        vecs[14] = '{OP_MADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 5};
        vecs[15] = '{OP_MTHI,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 0};
        vecs[16] = '{OP_MADDU, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000000, 5};
        vecs[17] = '{OP_MTLO,  32'h0000000A, 32'h00000000, 32'h00000000, 32'h0000000A, 0};
        vecs[18] = '{OP_MADD,  32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[19] = '{OP_MADDU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFC, 5};
        vecs[20] = '{OP_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 10};
        vecs[21] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};

        reset = 1'b1;
        start = 1'b1;
        op    = OP_MTHI;
        A     = 32'h0000FFFF;
        B     = 32'h0;

        // Reset held with a pending mthi: reset must win.
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_hi", HI, 32'h0);
        checkOutput("reset_lo", LO, 32'h0);
        reset = 1'b0;
        start = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            logic [31:0] pre_hi;
            logic [31:0] pre_lo;
            @(negedge clk);
            pre_hi = HI;
            pre_lo = LO;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkResult($sformatf("vec%0d", i), vecs[i].cycles, pre_hi, pre_lo,
                        vecs[i].exp_hi, vecs[i].exp_lo);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_fall", i), {31'd0, done}, 32'd0);
        end

        // Back-to-back: a new start in the done cycle is accepted immediately.
        @(negedge clk);
        applyStimulus(OP_MULT, 32'd2, 32'd3);
        checkResult("b2b_first", 5, 32'h00000002, 32'h0000000E, 32'h0, 32'd6);
        applyStimulus(OP_MULTU, 32'd4, 32'd5);
        checkResult("b2b_second", 5, 32'h0, 32'd6, 32'h0, 32'd20);

        // Reset during RUN, with ignored mtlo and mult issued while busy.
        @(negedge clk);
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        start = 1'b1;
        op    = OP_MTLO;
        A     = 32'h00001234;
        @(negedge clk);
        op    = OP_MULT;
        A     = 32'd9;
        B     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        checkOutput("abort_still_busy", {31'd0, busy}, 32'd1);
        checkOutput("abort_lo_ignored", LO, 32'd20);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_hi", HI, 32'h0);
        checkOutput("abort_lo", LO, 32'h0);
        repeat (12) @(negedge clk);
        checkOutput("abort_no_late_lo", LO, 32'h0);
        applyStimulus(OP_MULT, 32'd3, 32'd4);
        checkResult("after_abort", 5, 32'h0, 32'h0, 32'h0, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It extends the multi-cycle MIPS datapath with mult/multu/div/divu/madd/maddu/mthi/mtlo.
- Sits beside the ALU and is driven by the control unit.
- The control unit stalls PC/IR advance while busy=1 and reads HI/LO for mfhi/mflo.

Parameters:
WIDTH, 32, operand and HI/LO width (>=8)
MUL_CYCLES, 5, busy cycles for mult/multu/madd/maddu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  operation request, sampled at rising edge
op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu
A  input  WIDTH  operand A (rs), sampled with start
B  input  WIDTH  operand B (rt), sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse on the cycle results become visible
HI  output  WIDTH  HI register
LO  output  WIDTH  LO register

Behaviour:
- Reset: busy=0, done=0, HI=0, LO=0, counter=0, FSM=IDLE. Reset overrides start in the same cycle.
- FSM states: IDLE, RUN.
- IDLE, start=1, op in {0,1,2,3,6,7}:
  - latch op/A/B and load counter with N (MUL_CYCLES or DIV_CYCLES).
  - go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each cycle. busy is high for exactly N cycles. On the edge where the counter reaches its end:
  - HI/LO are written; FSM returns to IDLE.
  - busy=0 and done=1 in the same cycle, for one cycle.
  - Results are never visible before that cycle; HI/LO hold their old values throughout RUN.
- IDLE, start=1, op=4/5: HI<=A (mthi) or LO<=A (mtlo) at that edge. busy stays 0, done stays 0.
- start=1 while busy=1 (any op, including mthi/mtlo): ignored; no state change. Back-to-back ops are allowed: a start in the done cycle is accepted.
- mult: {HI,LO} = signed(A)*signed(B), 2*WIDTH result. multu: the same, unsigned.
- madd/maddu: {HI,LO} <= {HI,LO} + product. The signed or unsigned product is taken at WIDTH*2 bits. {HI,LO} is the value at completion time; the sum wraps modulo 2^(2*WIDTH).
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (A). divu: unsigned.
- Boundary conditions:
  - B=0 (div/divu): HI/LO unchanged. busy/done timing is still normal.
  - div overflow (A = most negative value, B = -1): LO = A, HI = 0.
  - reset during RUN: the operation is aborted, no result is written, all outputs take their reset values next cycle.
- Implementation is free (iterative shift-add/restoring divide, or single-cycle compute held by the counter) provided the cycle timing above is exact.

Test Plan:
- reset; mult A=0xFFFFFFFE, B=0x00000003 -> busy high exactly 5 cycles, then done=1 once, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- div A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=2 -> LO=3, HI=1.
- div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu with B=0 after HI=1/LO=3 -> HI=1, LO=3 unchanged, done still pulses after 10 cycles.
- mthi A=0, mtlo A=0xFFFFFFFF, then maddu A=1, B=1 -> busy 5 cycles, HI=1, LO=0. Then madd A=0xFFFFFFFF, B=1 -> HI=0, LO=0xFFFFFFFF.
- Start divu 100/7; in cycle 2 of busy assert start with mtlo A=0x1234 and a second start mult; at cycle 4 of busy assert reset -> both starts ignored, busy=0, done=0, HI=0, LO=0 next cycle. A new mult 3*4 started next then gives LO=12, HI=0.
